// File: rtl/chord_square_synth.sv
// Three-voice square-wave triad synthesizer for a 24-bit audio codec.
// The lowest pressed key selects the root; a free-running divider paces codec writes.
module chord_square_synth #(
  parameter logic [23:0] AMP        = 24'd2000000,
  parameter int unsigned SAMPLE_DIV = 1042
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic [17:0]        key_bus,
  input  logic               minor,
  input  logic               audio_out_allowed,
  output logic               write_audio_out,
  output logic signed [23:0] sample_out,
  output logic               playing
);

  localparam int unsigned       DIV_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic signed [23:0] AMP_S   = $signed(AMP);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t             state;
  logic [17:0]        key_q;
  logic               minor_q;
  logic [4:0]         root_idx;
  logic [4:0]         root_q;
  logic               minor_s;
  logic               note_present;
  logic               chord_change;
  logic [4:0]         note [3];
  logic [16:0]        half [3];
  logic [16:0]        cnt  [3];
  logic [2:0]         lvl;
  logic signed [23:0] voice_sum;
  logic signed [23:0] chord_q;
  logic [DIV_W-1:0]   div;
  logic               tick;
  logic               pending;

  function automatic logic [16:0] half_period(input logic [4:0] n);
    case (n)
      5'd0:    half_period = 17'd95556;
      5'd1:    half_period = 17'd90193;
      5'd2:    half_period = 17'd85131;
      5'd3:    half_period = 17'd80353;
      5'd4:    half_period = 17'd75843;
      5'd5:    half_period = 17'd71586;
      5'd6:    half_period = 17'd67569;
      5'd7:    half_period = 17'd63776;
      5'd8:    half_period = 17'd60197;
      5'd9:    half_period = 17'd56818;
      5'd10:   half_period = 17'd53629;
      5'd11:   half_period = 17'd50619;
      5'd12:   half_period = 17'd47778;
      5'd13:   half_period = 17'd45097;
      5'd14:   half_period = 17'd42566;
      5'd15:   half_period = 17'd40177;
      5'd16:   half_period = 17'd37922;
      5'd17:   half_period = 17'd35793;
      5'd18:   half_period = 17'd33784;
      5'd19:   half_period = 17'd31888;
      5'd20:   half_period = 17'd30098;
      5'd21:   half_period = 17'd28409;
      5'd22:   half_period = 17'd26815;
      5'd23:   half_period = 17'd25310;
      default: half_period = 17'd23889;
    endcase
  endfunction

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      key_q   <= '0;
      minor_q <= 1'b0;
    end else begin
      key_q   <= key_bus;
      minor_q <= minor;
    end
  end

  // Scan from the top down so the lowest set bit is the last assignment.
  always_comb begin
    note_present = |key_q;
    root_idx     = '0;
    for (int unsigned k = 0; k < 18; k++) begin
      if (key_q[17 - k]) root_idx = 5'(17 - k);
    end
    chord_change = (root_idx != root_q) || (minor_q != minor_s);
  end

  always_comb begin
    note[0]   = root_q;
    note[1]   = root_q + (minor_s ? 5'd3 : 5'd4);
    note[2]   = root_q + 5'd7;
    voice_sum = '0;
    for (int unsigned v = 0; v < 3; v++) begin
      half[v]   = half_period(note[v]);
      voice_sum = voice_sum + (lvl[v] ? AMP_S : -AMP_S);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state   <= IDLE;
      playing <= 1'b0;
      root_q  <= '0;
      minor_s <= 1'b0;
      lvl     <= '1;
      for (int unsigned v = 0; v < 3; v++) cnt[v] <= '0;
    end else begin
      case (state)
        IDLE: begin
          lvl <= '1;
          for (int unsigned v = 0; v < 3; v++) cnt[v] <= '0;
          if (note_present) begin
            state   <= PLAY;
            playing <= 1'b1;
            root_q  <= root_idx;
            minor_s <= minor_q;
          end
        end
        PLAY: begin
          if (!note_present) begin
            state   <= IDLE;
            playing <= 1'b0;
            lvl     <= '1;
            for (int unsigned v = 0; v < 3; v++) cnt[v] <= '0;
          end else if (chord_change) begin
            root_q  <= root_idx;
            minor_s <= minor_q;
            lvl     <= '1;
            for (int unsigned v = 0; v < 3; v++) cnt[v] <= '0;
          end else begin
            for (int unsigned v = 0; v < 3; v++) begin
              if (cnt[v] == half[v] - 17'd1) begin
                cnt[v] <= '0;
                lvl[v] <= ~lvl[v];
              end else begin
                cnt[v] <= cnt[v] + 17'd1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) chord_q <= '0;
    else       chord_q <= (state == PLAY) ? voice_sum : '0;
  end

  assign tick = (div == DIV_LAST);

  // The strobe is combinational so the codec captures sample_out before a
  // coincident tick replaces it; reset masks it on the reset edge itself.
  assign write_audio_out = pending & audio_out_allowed & ~reset;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      div        <= '0;
      pending    <= 1'b0;
      sample_out <= '0;
    end else begin
      div <= tick ? '0 : div + 1'b1;
      if (tick) begin
        sample_out <= chord_q;
        pending    <= 1'b1;
      end else if (write_audio_out) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_chord_square_synth.sv
// Directed bench: dut_a ticks every cycle to expose chord timing on sample_out,
// dut_b uses a short divider to exercise the codec handshake.
module tb_chord_square_synth;

  localparam logic signed [23:0] P6 = 24'sd6000000;
  localparam logic signed [23:0] P2 = 24'sd2000000;
  localparam logic signed [23:0] N2 = -24'sd2000000;
  localparam logic signed [23:0] Z  = 24'sd0;
  // Voices for root 16: fifth n=23, major third n=20, minor third n=19.
  localparam int H_FIFTH     = 25310;
  localparam int H_THIRD_MAJ = 30098;
  localparam int H_THIRD_MIN = 31888;

  logic               CLOCK_50 = 1'b0;
  logic               reset    = 1'b1;
  logic [17:0]        key_bus  = '0;
  logic               minor    = 1'b0;
  logic               allowed_a = 1'b1;
  logic               allowed_b = 1'b1;
  logic               wr_a, wr_b, play_a, play_b;
  logic signed [23:0] smp_a, smp_b;

  int checks = 0;
  int errors = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  chord_square_synth #(.AMP(24'd2000000), .SAMPLE_DIV(1)) dut_a (
    .CLOCK_50(CLOCK_50), .reset(reset), .key_bus(key_bus), .minor(minor),
    .audio_out_allowed(allowed_a), .write_audio_out(wr_a),
    .sample_out(smp_a), .playing(play_a)
  );

  chord_square_synth #(.AMP(24'd2000000), .SAMPLE_DIV(5)) dut_b (
    .CLOCK_50(CLOCK_50), .reset(reset), .key_bus(key_bus), .minor(minor),
    .audio_out_allowed(allowed_b), .write_audio_out(wr_b),
    .sample_out(smp_b), .playing(play_b)
  );

  task automatic step(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    key_bus = '0;
    minor   = 1'b0;
    step(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(2);
    checks++; if (smp_a !== Z) begin errors++; $display("FAIL reset_smp_a: got %0d expected %0d", smp_a, Z); end
    checks++; if (smp_b !== Z) begin errors++; $display("FAIL reset_smp_b: got %0d expected %0d", smp_b, Z); end
    checks++; if (wr_a !== 1'b0) begin errors++; $display("FAIL reset_wr_a: got %b expected 0", wr_a); end
    checks++; if (wr_b !== 1'b0) begin errors++; $display("FAIL reset_wr_b: got %b expected 0", wr_b); end
    checks++; if (play_a !== 1'b0) begin errors++; $display("FAIL reset_play_a: got %b expected 0", play_a); end
    checks++; if (play_b !== 1'b0) begin errors++; $display("FAIL reset_play_b: got %b expected 0", play_b); end
  endtask

  task automatic test_idle_ticks();
    int writes = 0;
    int bad = 0;
    allowed_b = 1'b1;
    do_reset();
    for (int i = 1; i <= 15; i++) begin
      step(1);
      if (wr_b === 1'b1) writes++;
      if (smp_b !== Z || play_b !== 1'b0) bad++;
    end
    checks++; if (writes != 3) begin errors++; $display("FAIL idle_writes: got %0d expected 3", writes); end
    checks++; if (bad != 0) begin errors++; $display("FAIL idle_sample_or_playing: got %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_major_chord();
    do_reset();
    key_bus = 18'h30000;
    step(1);
    checks++; if (play_a !== 1'b0) begin errors++; $display("FAIL major_play_k: got %b expected 0", play_a); end
    step(1);
    checks++; if (play_a !== 1'b1) begin errors++; $display("FAIL major_play_k1: got %b expected 1", play_a); end
    step(1);
    checks++; if (smp_a !== Z) begin errors++; $display("FAIL major_chord_k1: got %0d expected %0d", smp_a, Z); end
    step(1);
    checks++; if (smp_a !== P6) begin errors++; $display("FAIL major_chord_k2: got %0d expected %0d", smp_a, P6); end
    step(H_FIFTH - 1);
    checks++; if (smp_a !== P6) begin errors++; $display("FAIL major_pre_fifth: got %0d expected %0d", smp_a, P6); end
    step(1);
    checks++; if (smp_a !== P2) begin errors++; $display("FAIL major_fifth_toggle: got %0d expected %0d", smp_a, P2); end
    step(H_THIRD_MAJ - H_FIFTH - 1);
    checks++; if (smp_a !== P2) begin errors++; $display("FAIL major_pre_third: got %0d expected %0d", smp_a, P2); end
    step(1);
    checks++; if (smp_a !== N2) begin errors++; $display("FAIL major_third_toggle: got %0d expected %0d", smp_a, N2); end
  endtask

  task automatic test_minor_restart();
    minor = 1'b1;
    step(2);
    checks++; if (play_a !== 1'b1) begin errors++; $display("FAIL minor_play_held: got %b expected 1", play_a); end
    step(1);
    checks++; if (smp_a !== N2) begin errors++; $display("FAIL minor_before_restart: got %0d expected %0d", smp_a, N2); end
    step(1);
    checks++; if (smp_a !== P6) begin errors++; $display("FAIL minor_restart_chord: got %0d expected %0d", smp_a, P6); end
    step(H_FIFTH - 1);
    checks++; if (smp_a !== P6) begin errors++; $display("FAIL minor_pre_fifth: got %0d expected %0d", smp_a, P6); end
    step(1);
    checks++; if (smp_a !== P2) begin errors++; $display("FAIL minor_fifth_toggle: got %0d expected %0d", smp_a, P2); end
    step(H_THIRD_MIN - H_FIFTH - 1);
    checks++; if (smp_a !== P2) begin errors++; $display("FAIL minor_pre_third: got %0d expected %0d", smp_a, P2); end
    step(1);
    checks++; if (smp_a !== N2) begin errors++; $display("FAIL minor_third_toggle: got %0d expected %0d", smp_a, N2); end
  endtask

  task automatic test_release();
    key_bus = '0;
    step(1);
    checks++; if (play_a !== 1'b1) begin errors++; $display("FAIL release_play_k: got %b expected 1", play_a); end
    step(1);
    checks++; if (play_a !== 1'b0) begin errors++; $display("FAIL release_play_k1: got %b expected 0", play_a); end
    step(1);
    checks++; if (smp_a !== N2) begin errors++; $display("FAIL release_chord_k1: got %0d expected %0d", smp_a, N2); end
    step(1);
    checks++; if (smp_a !== Z) begin errors++; $display("FAIL release_chord_k2: got %0d expected %0d", smp_a, Z); end
    minor = 1'b0;
  endtask

  task automatic test_backpressure();
    int writes = 0;
    allowed_b = 1'b0;
    do_reset();
    key_bus = 18'h20000;
    for (int i = 1; i <= 15; i++) begin
      step(1);
      if (wr_b === 1'b1) writes++;
      if (i == 5) begin
        checks++; if (smp_b !== P6) begin errors++; $display("FAIL bp_tick1: got %0d expected %0d", smp_b, P6); end
      end
      if (i == 9) key_bus = '0;
      if (i == 10) begin
        checks++; if (smp_b !== P6) begin errors++; $display("FAIL bp_tick2: got %0d expected %0d", smp_b, P6); end
      end
    end
    checks++; if (smp_b !== Z) begin errors++; $display("FAIL bp_tick3: got %0d expected %0d", smp_b, Z); end
    checks++; if (writes != 0) begin errors++; $display("FAIL bp_blocked_writes: got %0d expected 0", writes); end
    allowed_b = 1'b1;
    #1;
    checks++; if (wr_b !== 1'b1) begin errors++; $display("FAIL bp_release_write: got %b expected 1", wr_b); end
    checks++; if (smp_b !== Z) begin errors++; $display("FAIL bp_release_value: got %0d expected %0d", smp_b, Z); end
    writes = 0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      if (wr_b === 1'b1) writes++;
    end
    checks++; if (writes != 0) begin errors++; $display("FAIL bp_single_write: got %0d extra writes expected 0", writes); end
  endtask

  task automatic test_back_to_back();
    allowed_b = 1'b0;
    do_reset();
    key_bus = 18'h20000;
    step(5);
    checks++; if (smp_b !== P6) begin errors++; $display("FAIL b2b_first_tick: got %0d expected %0d", smp_b, P6); end
    key_bus = '0;
    step(4);
    allowed_b = 1'b1;
    #1;
    checks++; if (wr_b !== 1'b1 || smp_b !== P6) begin errors++; $display("FAIL b2b_old_write: got wr=%b smp=%0d expected wr=1 smp=%0d", wr_b, smp_b, P6); end
    step(1);
    checks++; if (wr_b !== 1'b1 || smp_b !== Z) begin errors++; $display("FAIL b2b_new_pending: got wr=%b smp=%0d expected wr=1 smp=%0d", wr_b, smp_b, Z); end
    step(1);
    checks++; if (wr_b !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %b expected 0", wr_b); end
  endtask

  task automatic test_reset_mid_play();
    allowed_b = 1'b0;
    do_reset();
    key_bus = 18'h20000;
    step(8);
    checks++; if (play_b !== 1'b1 || smp_b !== P6) begin errors++; $display("FAIL midplay_setup: got play=%b smp=%0d expected play=1 smp=%0d", play_b, smp_b, P6); end
    reset     = 1'b1;
    key_bus   = '0;
    allowed_b = 1'b1;
    #1;
    checks++; if (wr_b !== 1'b0) begin errors++; $display("FAIL midplay_wr_during_reset: got %b expected 0", wr_b); end
    step(1);
    reset = 1'b0;
    #1;
    checks++; if (smp_a !== Z || smp_b !== Z) begin errors++; $display("FAIL midplay_sample: got a=%0d b=%0d expected 0", smp_a, smp_b); end
    checks++; if (play_a !== 1'b0 || play_b !== 1'b0) begin errors++; $display("FAIL midplay_playing: got a=%b b=%b expected 0", play_a, play_b); end
    checks++; if (wr_a !== 1'b0 || wr_b !== 1'b0) begin errors++; $display("FAIL midplay_wr_after: got a=%b b=%b expected 0", wr_a, wr_b); end
    step(1);
    checks++; if (wr_b !== 1'b0 || play_b !== 1'b0) begin errors++; $display("FAIL midplay_idle_next: got wr=%b play=%b expected 0", wr_b, play_b); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_idle_ticks();
    test_major_chord();
    test_minor_restart();
    test_release();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_play();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/chord_square_synth.md
CHORD_SQUARE_SYNTH -- requirements
Module: chord_square_synth

Interface
REQ-001 Parameter: AMP, default 24'd2000000, per-voice square amplitude (unsigned magnitude).
REQ-002 Parameter: SAMPLE_DIV, default 1042, clk cycles per audio sample tick (48 kHz at 50 MHz).
REQ-003 Port: CLOCK_50  in  1  system clock; the block's only clock, all logic on its rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: key_bus  in  18  note-key bus from the PS2 key decoder; bit n = semitone n above C4.
REQ-006 Port: minor  in  1  0 = major triad, 1 = minor triad.
REQ-007 Port: audio_out_allowed  in  1  codec FIFO has space.
REQ-008 Port: write_audio_out  out  1  one-cycle write strobe to codec.
REQ-009 Port: sample_out  out  24  signed chord sample presented to codec.
REQ-010 Port: playing  out  1  high while state PLAY.

Function
REQ-011 key_bus and minor SHALL be registered once (key_q, minor_q) before use.
REQ-012 Root index r SHALL be the lowest set bit of key_q; key_q==0 means no note.
REQ-013 Voices: root n=r, third n=r+4 (major) or r+3 (minor), fifth n=r+7; n range 0..24.
REQ-014 Half-period ROM: HALF[n] = round(50e6 / (2 * 261.6256 * 2^(n/12))), 25 constant entries; e.g. HALF[0]=95556, HALF[3]=80353, HALF[4]=75843, HALF[7]=63776, HALF[9]=56818, HALF[12]=47778.
REQ-015 FSM states IDLE, PLAY; IDLE->PLAY when note present; PLAY->IDLE when key_q==0; PLAY->PLAY restart when r or minor_q differs from stored root_q/minor_s.
REQ-016 On entry to PLAY or restart: store r/minor, clear all three phase counters to 0, set all three levels high (+1).
REQ-017 Each voice counter SHALL count 0..HALF[n]-1; on the edge where counter==HALF[n]-1, counter<=0 and level toggles (period 2*HALF[n] cycles).
REQ-018 In IDLE counters SHALL hold 0, levels high, and the chord value SHALL be 0.
REQ-019 Chord value (registered each cycle) = sum over voices of (+AMP if level high else -AMP), 24-bit signed; range +-3*AMP, no saturation needed for AMP <= 2796202.
REQ-020 Latency: key_bus change at edge k -> key_q at k -> state/counters updated at k+1 -> chord value reflects it at k+2.
REQ-021 Sample tick: free-running divider counting 0..SAMPLE_DIV-1, independent of state; at terminal count chord value SHALL be copied to sample_out and pending set.
REQ-022 write_audio_out SHALL be high for exactly one cycle when pending && audio_out_allowed; pending clears on that same edge.
REQ-023 Tick while pending still set: sample_out overwritten with newest value, pending stays set, only one write issued (oldest sample dropped).
REQ-024 Tick and write in the same cycle: write consumes the old sample_out; new value loads and pending remains set.
REQ-025 playing SHALL equal (state==PLAY), registered.

Reset
REQ-026 On reset: state IDLE, key_q=0, minor_q=0, counters 0, levels high, divider 0, pending 0, sample_out=0, write_audio_out=0, playing=0.
REQ-027 Reset asserted mid-PLAY SHALL override all other updates on that edge; no write strobe during or on the edge after reset.

Verification
REQ-028 Reset, key_bus=0, audio_out_allowed=1 for 3*SAMPLE_DIV cycles -> sample_out=0 every tick, one write per tick, playing=0.
REQ-029 key_bus=18'h00001, minor=0 -> chord value 6000000 at k+2; fifth toggles after 63776 cycles of PLAY, chord 2000000 next cycle; third toggles at 75843, chord -2000000.
REQ-030 key_bus=18'h00201 (bits 0 and 9) -> root n=0 wins; third period 2*75843 cycles measured on level.
REQ-031 In PLAY toggle minor 0->1 -> restart: counters 0, chord 6000000, third now toggles after 80353 cycles; release key -> chord 0 and playing=0 by k+2.
REQ-032 audio_out_allowed=0 across 3 ticks, then 1 -> exactly one write, carrying the value latched at the third tick.
REQ-033 Assert reset mid-PLAY with pending set -> next cycle all outputs 0, no write strobe, state IDLE.
